// File: rtl/ahb_prot_sram.sv
// AHB-Lite word SRAM subordinate with address/control parity and data checksums.
// Define PROT_SRAM_ERRCNT_EN to add the saturating s_err_cnt_o error counter.
module ahb_prot_sram #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 1024
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_hsel_i,
    input  logic [31:0] s_haddr_i,
    input  logic [1:0]  s_htrans_i,
    input  logic [2:0]  s_hsize_i,
    input  logic        s_hwrite_i,
    input  logic        s_hready_i,
    input  logic [5:0]  s_hparity_i,
    input  logic [31:0] s_hwdata_i,
    input  logic [6:0]  s_hwchecksum_i,
    output logic [31:0] s_hrdata_o,
    output logic [6:0]  s_hrchecksum_o,
    output logic        s_hreadyout_o,
    output logic        s_hresp_o,
`ifdef PROT_SRAM_ERRCNT_EN
    output logic        s_err_o,
    output logic [7:0]  s_err_cnt_o
`else
    output logic        s_err_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

    state_t      state, state_nxt;
    logic [31:0] mem [DEPTH];
    logic        a_wr;
    logic [AW-1:0] a_idx;
    logic [1:0]  a_size;
    logic [1:0]  a_lo;
    logic [5:0]  par;
    logic [31:0] off;
    logic        in_win, misalign, addr_err;
    logic        wr_err, accept, we;
    logic [3:0]  be;
    logic        unused_bits;

    function automatic logic [6:0] csum(input logic [31:0] d);
        logic [6:0] c;
        c = '0;
        for (int k = 0; k < 4; k++) c[k] = ^d[8*k +: 8];
        for (int i = 0; i < 32; i += 3) c[4] = c[4] ^ d[i];
        for (int i = 1; i < 32; i += 3) c[5] = c[5] ^ d[i];
        for (int i = 2; i < 32; i += 3) c[6] = c[6] ^ d[i];
        return c;
    endfunction

    assign par = {^s_htrans_i, ^{s_hwrite_i, s_hsize_i},
                  ^s_haddr_i[31:24], ^s_haddr_i[23:16],
                  ^s_haddr_i[15:8], ^s_haddr_i[7:0]};
    assign off      = s_haddr_i - BASE_ADDR;
    assign in_win   = (s_haddr_i >= BASE_ADDR) && (off < SPAN);
    assign misalign = ((s_hsize_i == 3'd1) && s_haddr_i[0])
                   || ((s_hsize_i == 3'd2) && (s_haddr_i[1:0] != 2'b00));
    assign addr_err = (par != s_hparity_i) || !in_win
                   || (s_hsize_i > 3'd2) || misalign;

    // A bad write checksum turns the data-phase cycle itself into ERR1.
    assign wr_err = (state == DATA) && a_wr
                 && (csum(s_hwdata_i) != s_hwchecksum_i);
    assign accept = s_hsel_i && s_hready_i && s_htrans_i[1]
                 && (state != ERR1) && !wr_err;
    assign we     = (state == DATA) && a_wr && !wr_err;
    assign unused_bits = ^{off[31:AW+2], off[1:0]};

    always_comb begin
        state_nxt     = IDLE;
        s_hreadyout_o = 1'b1;
        s_hresp_o     = 1'b0;
        s_err_o       = 1'b0;
        if (state == ERR1 || wr_err) begin
            state_nxt     = ERR2;
            s_hreadyout_o = 1'b0;
            s_hresp_o     = 1'b1;
            s_err_o       = 1'b1;
        end else begin
            if (state == ERR2) s_hresp_o = 1'b1;
            if (accept) state_nxt = addr_err ? ERR1 : DATA;
        end
    end

    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            state  <= IDLE;
            a_wr   <= 1'b0;
            a_idx  <= '0;
            a_size <= '0;
            a_lo   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_wr   <= s_hwrite_i;
                a_idx  <= off[AW+1:2];
                a_size <= s_hsize_i[1:0];
                a_lo   <= s_haddr_i[1:0];
            end
        end
    end

    always_comb begin
        be = 4'b0000;
        unique case (a_size)
            2'd0:    be = 4'b0001 << a_lo;
            2'd1:    be = a_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge s_clk_i) begin
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[a_idx][8*b +: 8] <= s_hwdata_i[8*b +: 8];
        end
    end

    assign s_hrdata_o     = (state == DATA && !a_wr) ? mem[a_idx] : '0;
    assign s_hrchecksum_o = csum(s_hrdata_o);

`ifdef PROT_SRAM_ERRCNT_EN
    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) s_err_cnt_o <= '0;
        else if (s_err_o && s_err_cnt_o != 8'hFF) s_err_cnt_o <= s_err_cnt_o + 8'd1;
    end
`endif
endmodule

// File: tb/tb_ahb_prot_sram.sv
// Randomised scoreboard bench for ahb_prot_sram against a word-level memory model.
// Honours PROT_SRAM_ERRCNT_EN when the design is built with it.
module tb_ahb_prot_sram;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int DEPTH = 1024;
    localparam longint HI = longint'(BASE) + 4 * DEPTH;

    typedef enum int {K_IDLE, K_ERR1, K_ERR2, K_RD, K_WR} kind_t;
    typedef struct {
        bit sel; logic [1:0] trans; logic [31:0] addr; logic [2:0] size;
        bit write; logic [5:0] pflip; logic [31:0] wdata; logic [6:0] cflip;
    } xfer_t;
    typedef struct {
        kind_t kind; int idx; int size; int lo;
        logic [31:0] wdata; logic [6:0] wchk;
    } pend_t;
    typedef struct {
        bit ready; bit resp; bit err; bit chk_rd; logic [31:0] rdata; int cnt;
    } exp_t;

    logic clk, rst;
    logic hsel, hwrite, hready, hreadyout, hresp, err;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0] htrans;
    logic [2:0] hsize;
    logic [5:0] hparity;
    logic [6:0] hwchk, hrchk;
`ifdef PROT_SRAM_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;
    exp_t sbq[$];
    exp_t me;
    pend_t pend;
    logic [31:0] mem_m [DEPTH];
    int cnt_m = 0;

    assign hready = hreadyout;

    ahb_prot_sram #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .s_clk_i(clk), .s_reset_i(rst), .s_hsel_i(hsel), .s_haddr_i(haddr),
        .s_htrans_i(htrans), .s_hsize_i(hsize), .s_hwrite_i(hwrite),
        .s_hready_i(hready), .s_hparity_i(hparity), .s_hwdata_i(hwdata),
        .s_hwchecksum_i(hwchk), .s_hrdata_o(hrdata), .s_hrchecksum_o(hrchk),
        .s_hreadyout_o(hreadyout), .s_hresp_o(hresp),
`ifdef PROT_SRAM_ERRCNT_EN
        .s_err_o(err), .s_err_cnt_o(err_cnt)
`else
        .s_err_o(err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    function automatic logic [6:0] csum_m(input logic [31:0] d);
        logic [6:0] c;
        int n;
        for (int k = 0; k < 4; k++) c[k] = ($countones(d[8*k +: 8]) % 2) == 1;
        for (int j = 0; j < 3; j++) begin
            n = 0;
            for (int i = 0; i < 32; i++) if (i % 3 == j) n += int'(d[i]);
            c[4+j] = (n % 2) == 1;
        end
        return c;
    endfunction

    function automatic logic [5:0] par_m(input xfer_t x);
        logic [5:0] p;
        for (int k = 0; k < 4; k++) p[k] = ($countones(x.addr[8*k +: 8]) % 2) == 1;
        p[4] = ($countones({x.write, x.size}) % 2) == 1;
        p[5] = ($countones(x.trans) % 2) == 1;
        return p;
    endfunction

    function automatic bit addr_bad(input xfer_t x);
        longint a;
        a = longint'(x.addr);
        return a < longint'(BASE) || a >= HI || x.size > 3'd2
            || (x.size == 3'd1 && a % 2 != 0) || (x.size == 3'd2 && a % 4 != 0)
            || x.pflip != 6'd0;
    endfunction

    function automatic xfer_t mk(input bit sel, input logic [1:0] tr, input logic [31:0] a,
                                 input logic [2:0] sz, input bit wr, input logic [31:0] wd);
        xfer_t x;
        x.sel = sel; x.trans = tr; x.addr = a; x.size = sz; x.write = wr;
        x.pflip = 6'd0; x.wdata = wd; x.cflip = 7'd0;
        return x;
    endfunction

    function automatic xfer_t idle_x();
        return mk(1'b0, 2'd0, 32'd0, 3'd0, 1'b0, 32'd0);
    endfunction

    function automatic xfer_t rnd_xfer();
        xfer_t x;
        int r;
        x.sel = $urandom_range(0, 9) != 0;
        r = $urandom_range(0, 9);
        x.trans = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : (r < 6) ? 2'd2 : 2'd3;
        x.write = 1'($urandom_range(0, 1));
        x.size = ($urandom_range(0, 19) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        x.addr = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
        if (x.size == 3'd0) x.addr += 32'($urandom_range(0, 3));
        if (x.size == 3'd1) x.addr += 32'($urandom_range(0, 1)) * 2;
        if ($urandom_range(0, 15) == 0) x.addr += 32'($urandom_range(1, 3));
        if ($urandom_range(0, 19) == 0) x.addr = 32'(HI) + 32'($urandom_range(0, 255)) * 4;
        x.pflip = ($urandom_range(0, 11) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'd0;
        x.wdata = $urandom;
        x.cflip = ($urandom_range(0, 9) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'd0;
        return x;
    endfunction

    // One bus cycle: predict this cycle's data-phase response, then drive the address phase.
    task automatic cycle(input xfer_t x);
        exp_t e;
        pend_t np;
        bit e1;
        int nb, first;
        e.ready = 1; e.resp = 0; e.err = 0; e.chk_rd = 1; e.rdata = 32'd0; e.cnt = cnt_m;
        e1 = 0;
        case (pend.kind)
            K_ERR1: e1 = 1;
            K_ERR2: e.resp = 1;
            K_RD:   e.rdata = mem_m[pend.idx];
            K_WR: begin
                e.chk_rd = 0;
                if (csum_m(pend.wdata) != pend.wchk) e1 = 1;
                else begin
                    nb = 1 << pend.size;
                    first = (pend.lo / nb) * nb;
                    for (int b = first; b < first + nb; b++)
                        mem_m[pend.idx][8*b +: 8] = pend.wdata[8*b +: 8];
                end
            end
            default: ;
        endcase
        if (e1) begin
            e.ready = 0; e.resp = 1; e.err = 1;
            x.trans = 2'd0;
            if (cnt_m < 255) cnt_m++;
        end
        sbq.push_back(e);
        np.kind = e1 ? K_ERR2 : K_IDLE;
        np.idx = 0; np.size = 0; np.lo = 0; np.wdata = 32'd0; np.wchk = 7'd0;
        if (!e1 && x.sel && x.trans[1]) begin
            if (addr_bad(x)) np.kind = K_ERR1;
            else begin
                np.kind = x.write ? K_WR : K_RD;
                np.idx = int'((x.addr - BASE) / 4);
                np.size = int'(x.size);
                np.lo = int'(x.addr % 4);
                np.wdata = x.wdata;
                np.wchk = csum_m(x.wdata) ^ x.cflip;
            end
        end
        hsel = x.sel; haddr = x.addr; htrans = x.trans; hsize = x.size;
        hwrite = x.write; hparity = par_m(x) ^ x.pflip;
        hwdata = (pend.kind == K_WR) ? pend.wdata : $urandom;
        hwchk = (pend.kind == K_WR) ? pend.wchk : 7'($urandom);
        pend = np;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty actual=0 expected=1");
            end else begin
                me = sbq.pop_front();
                check("hreadyout", 32'(hreadyout), 32'(me.ready));
                check("hresp", 32'(hresp), 32'(me.resp));
                check("err", 32'(err), 32'(me.err));
                if (me.chk_rd) begin
                    check("hrdata", hrdata, me.rdata);
                    check("hrchecksum", 32'(hrchk), 32'(csum_m(me.rdata)));
                end
`ifdef PROT_SRAM_ERRCNT_EN
                check("errcnt", 32'(err_cnt), 32'(me.cnt));
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        xfer_t x;
        rst = 1'b1;
        hsel = 0; haddr = 0; htrans = 0; hsize = 0; hwrite = 0;
        hparity = 0; hwdata = 0; hwchk = 0;
        pend.kind = K_IDLE; pend.idx = 0; pend.size = 0; pend.lo = 0;
        pend.wdata = 0; pend.wchk = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hreadyout", 32'(hreadyout), 32'd1);
        check("rst_hresp", 32'(hresp), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        check("rst_hrchecksum", 32'(hrchk), 32'd0);
`ifdef PROT_SRAM_ERRCNT_EN
        check("rst_errcnt", 32'(err_cnt), 32'd0);
`endif
        rst = 1'b0;
        mon_en = 1;

        for (int w = 0; w < DEPTH; w++)
            cycle(mk(1, 2'd2, BASE + 32'(w) * 4, 3'd2, 1, $urandom));
        cycle(idle_x());

        cycle(mk(1, 2'd2, BASE + 32'h10, 3'd2, 1, 32'hDEADBEEF));
        cycle(mk(1, 2'd2, BASE + 32'h10, 3'd2, 0, 32'd0));
        cycle(idle_x());

        cycle(mk(1, 2'd2, BASE + 32'h20, 3'd2, 1, 32'h0000_0000));
        cycle(mk(1, 2'd2, BASE + 32'h22, 3'd0, 1, 32'h11A5_2233));
        cycle(mk(1, 2'd2, BASE + 32'h20, 3'd2, 0, 32'd0));
        cycle(idle_x());

        x = mk(1, 2'd2, BASE + 32'h30, 3'd2, 1, 32'hCAFE_F00D);
        x.pflip = 6'd1;
        cycle(x);
        cycle(idle_x());
        cycle(mk(1, 2'd2, BASE + 32'h30, 3'd2, 0, 32'd0));
        cycle(idle_x());

        x = mk(1, 2'd2, BASE + 32'h40, 3'd2, 1, 32'h1234_5678);
        x.cflip = 7'h40;
        cycle(x);
        cycle(idle_x());
        cycle(idle_x());
        cycle(mk(1, 2'd2, BASE + 32'h40, 3'd2, 0, 32'd0));
        cycle(idle_x());

        cycle(mk(1, 2'd2, 32'(HI), 3'd2, 0, 32'd0));
        cycle(idle_x());
        cycle(mk(1, 2'd2, BASE + 32'h02, 3'd2, 0, 32'd0));
        cycle(idle_x());
        cycle(mk(1, 2'd2, BASE + 32'h50, 3'd3, 0, 32'd0));
        cycle(idle_x());
        cycle(idle_x());

        repeat (1500) cycle(rnd_xfer());
        cycle(idle_x());
        cycle(idle_x());

`ifdef PROT_SRAM_ERRCNT_EN
        repeat (300) begin
            cycle(mk(1, 2'd2, 32'(HI), 3'd2, 0, 32'd0));
            cycle(idle_x());
        end
        cycle(idle_x());
        check("errcnt_sat", 32'(err_cnt), 32'hFF);
`endif

        cycle(mk(1, 2'd2, BASE + 32'h02, 3'd2, 0, 32'd0));
        mon_en = 0;
        sbq.delete();
        #1;
        check("pre_rst_hreadyout", 32'(hreadyout), 32'd0);
        rst = 1'b1;
        #1;
        check("async_rst_hreadyout", 32'(hreadyout), 32'd1);
        check("async_rst_hresp", 32'(hresp), 32'd0);
        check("async_rst_err", 32'(err), 32'd0);
`ifdef PROT_SRAM_ERRCNT_EN
        check("async_rst_errcnt", 32'(err_cnt), 32'd0);
`endif
        hsel = 0; htrans = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pend.kind = K_IDLE;
        cnt_m = 0;
        mon_en = 1;
        cycle(mk(1, 2'd2, BASE + 32'h10, 3'd2, 0, 32'd0));
        cycle(mk(1, 2'd2, BASE + 32'h40, 3'd2, 0, 32'd0));
        cycle(idle_x());
        mon_en = 0;
        check("sb_drain", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
